// File: rtl/motor_pwm_frame_controller.sv
// motor_pwm_frame_controller: shared PWM timebase with shadow/staged compare sets, arm FSM and frame watchdog
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   enable               timebase runs when high, otherwise timer cleared and held
//   period               frame length in cycles (values below 2 behave as 2)
//   idle_value           compare value driven on every channel when not ARMED
//   arm_req              level request to arm the bank
//   ch_wr_en/sel/data    shadow register write port (out-of-range selects ignored)
//   commit               copy the shadow set (including a same-cycle write) into the staged set
//   wdog_frames          frames allowed without a commit while ARMED, 0 disables
//   timer_value          shared timebase
//   compare_value        per-channel compare, channel i at [i*TIMER_WIDTH +: TIMER_WIDTH]
//   compare_value_latch  strobe on the last cycle of each frame; frame_start is identical
//   state, failsafe      0 DISARMED, 1 ARMED, 2 FAILSAFE; failsafe flags state 2
module motor_pwm_frame_controller #(
  parameter int TIMER_WIDTH = 32,
  parameter int NUM_CH      = 4,
  parameter int WDOG_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          enable,
  input  logic [TIMER_WIDTH-1:0]        period,
  input  logic [TIMER_WIDTH-1:0]        idle_value,
  input  logic                          arm_req,
  input  logic                          ch_wr_en,
  input  logic [$clog2(NUM_CH)-1:0]     ch_wr_sel,
  input  logic [TIMER_WIDTH-1:0]        ch_wr_data,
  input  logic                          commit,
  input  logic [WDOG_WIDTH-1:0]         wdog_frames,
  output logic [TIMER_WIDTH-1:0]        timer_value,
  output logic [NUM_CH*TIMER_WIDTH-1:0] compare_value,
  output logic                          compare_value_latch,
  output logic                          frame_start,
  output logic [1:0]                    state,
  output logic                          failsafe
);
  localparam logic [1:0] DISARMED = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] FAILSAFE = 2'd2;
  logic [TIMER_WIDTH-1:0] last;
  logic                   boundary;
  logic                   wr_hit;
  logic [TIMER_WIDTH-1:0] shadow    [NUM_CH];
  logic [TIMER_WIDTH-1:0] shadow_nx [NUM_CH];
  logic [TIMER_WIDTH-1:0] staged    [NUM_CH];
  logic [1:0]             state_nx;
  logic [WDOG_WIDTH-1:0]  wdog;
  logic                   commit_seen;
  logic                   wdog_expire;
  logic                   arming;
  logic                   disarming;
  // last cycle index of the frame; >= rather than == lets a shrinking period wrap at once
  assign last                = (period < TIMER_WIDTH'(2)) ? TIMER_WIDTH'(1) : period - TIMER_WIDTH'(1);
  assign boundary            = enable && (timer_value >= last);
  assign compare_value_latch = boundary;
  assign frame_start         = boundary;
  assign wr_hit              = ch_wr_en && (32'(ch_wr_sel) < NUM_CH);
  assign wdog_expire         = (wdog_frames != '0) && boundary && !commit &&
                               (wdog == wdog_frames - WDOG_WIDTH'(1));
  assign arming              = (state == DISARMED) && (state_nx == ARMED);
  assign disarming           = (state != DISARMED) && (state_nx == DISARMED);
  // shadow view including this cycle's write, so commit captures a same-cycle write
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      shadow_nx[i] = (wr_hit && (32'(ch_wr_sel) == i)) ? ch_wr_data : shadow[i];
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) timer_value <= '0;
    else       timer_value <= (!enable || boundary) ? '0 : timer_value + TIMER_WIDTH'(1);
  end
  // staged updates as a whole set in one edge, so generators never see a partial set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        staged[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= shadow_nx[i];
        if (commit) staged[i] <= shadow_nx[i];
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= DISARMED;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = (state == DISARMED) ? ((arm_req && commit_seen && boundary) ? ARMED : DISARMED) :
               (state == ARMED)    ? (!arm_req ? DISARMED : (wdog_expire ? FAILSAFE : ARMED)) :
                                     (!arm_req ? DISARMED : FAILSAFE);
  end
  always_comb begin
    failsafe = state == FAILSAFE;
    for (int i = 0; i < NUM_CH; i++)
      compare_value[i*TIMER_WIDTH +: TIMER_WIDTH] = (state == ARMED) ? staged[i] : idle_value;
  end
  // commit beats a boundary increment; the count saturates rather than wrapping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog        <= '0;
      commit_seen <= 1'b0;
    end else begin
      wdog        <= (commit || arming) ? '0 :
                     ((state == ARMED) && boundary && (wdog != '1)) ? wdog + WDOG_WIDTH'(1) : wdog;
      commit_seen <= disarming ? 1'b0 : (commit ? 1'b1 : commit_seen);
    end
  end
endmodule

// File: tb/tb_motor_pwm_frame_controller.sv
// tb_motor_pwm_frame_controller: scoreboard bench for the frame controller
module tb_motor_pwm_frame_controller;
  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         enable;
  logic [31:0]  period;
  logic [31:0]  idle_value;
  logic         arm_req;
  logic         ch_wr_en;
  logic [1:0]   ch_wr_sel;
  logic [31:0]  ch_wr_data;
  logic         commit;
  logic [7:0]   wdog_frames;
  logic [31:0]  timer_value;
  logic [127:0] compare_value;
  logic         compare_value_latch;
  logic         frame_start;
  logic [1:0]   state;
  logic         failsafe;
  logic         arm3, wr3, com3;
  logic [1:0]   sel3;
  logic [31:0]  dat3;
  logic [31:0]  tmr3;
  logic [95:0]  cv3;
  logic         lat3, fs3, fail3;
  logic [1:0]   st3;
  logic [127:0] q[$];
  int           total = 0;
  int           bad = 0;
  int           m;
  always #5 clk = ~clk;
  motor_pwm_frame_controller dut (
    .clk(clk), .rstn(rstn), .enable(enable), .period(period), .idle_value(idle_value),
    .arm_req(arm_req), .ch_wr_en(ch_wr_en), .ch_wr_sel(ch_wr_sel), .ch_wr_data(ch_wr_data),
    .commit(commit), .wdog_frames(wdog_frames), .timer_value(timer_value),
    .compare_value(compare_value), .compare_value_latch(compare_value_latch),
    .frame_start(frame_start), .state(state), .failsafe(failsafe)
  );
  motor_pwm_frame_controller #(.NUM_CH(3)) dut3 (
    .clk(clk), .rstn(rstn), .enable(1'b1), .period(32'd4), .idle_value(32'd0),
    .arm_req(arm3), .ch_wr_en(wr3), .ch_wr_sel(sel3), .ch_wr_data(dat3),
    .commit(com3), .wdog_frames(8'd0), .timer_value(tmr3),
    .compare_value(cv3), .compare_value_latch(lat3),
    .frame_start(fs3), .state(st3), .failsafe(fail3)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] vec4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_timer(input logic [31:0] v);
    for (int n = 0; n < 40 && timer_value != v; n++) tick;
    chk("wait_timer", timer_value, v);
  endtask
  // generators capture compare_value on the strobe edge; check what they would capture
  always @(negedge clk) begin
    if (rstn && compare_value_latch && q.size() != 0) chk("frame_cv", compare_value, q.pop_front());
  end
  initial begin
    logic [127:0] idle4;
    logic [127:0] set1;
    logic [127:0] set2;
    enable = 1'b1; period = 32'd10; idle_value = 32'hAA; arm_req = 1'b0;
    ch_wr_en = 1'b0; ch_wr_sel = 2'd0; ch_wr_data = '0; commit = 1'b0; wdog_frames = 8'd0;
    arm3 = 1'b0; wr3 = 1'b0; com3 = 1'b0; sel3 = 2'd0; dat3 = '0;
    idle4 = vec4(32'hAA, 32'hAA, 32'hAA, 32'hAA);
    set1  = vec4(32'd3, 32'd5, 32'd7, 32'd9);
    set2  = vec4(32'd3, 32'd8, 32'd7, 32'd9);
    #12;
    chk("rst_timer", timer_value, 0);
    chk("rst_latch", {frame_start, compare_value_latch}, 0);
    chk("rst_state", state, 0);
    chk("rst_cv", compare_value, idle4);
    #10 rstn = 1'b1;
    m = 0;
    for (int i = 0; i < 25; i++) begin
      chk("t1_timer", timer_value, m);
      chk("t1_latch", {frame_start, compare_value_latch}, (m == 9) ? 2'b11 : 2'b00);
      tick;
      m = (m == 9) ? 0 : m + 1;
    end
    wait_timer(0);
    period = 32'd1;
    m = 0;
    for (int i = 0; i < 6; i++) begin
      chk("p1_timer", timer_value, m);
      chk("p1_latch", compare_value_latch, m == 1);
      tick;
      m = 1 - m;
    end
    period = 32'd10;
    wait_timer(7);
    period = 32'd5;
    #1;
    chk("shrink_latch", compare_value_latch, 1);
    tick;
    chk("shrink_wrap", timer_value, 0);
    period = 32'd10;
    wait_timer(1);
    ch_wr_en = 1'b1; ch_wr_sel = 2'd0; ch_wr_data = 32'd3; tick;
    ch_wr_sel = 2'd1; ch_wr_data = 32'd5; tick;
    ch_wr_sel = 2'd2; ch_wr_data = 32'd7; tick;
    chk("t2_at4", timer_value, 4);
    ch_wr_sel = 2'd3; ch_wr_data = 32'd9; commit = 1'b1; arm_req = 1'b1; tick;
    ch_wr_en = 1'b0; commit = 1'b0;
    q.push_back(idle4);
    chk("t2_still_disarmed", state, 0);
    wait_timer(0);
    chk("t2_armed", state, 1);
    chk("t2_cv", compare_value, set1);
    q.push_back(set1);
    wait_timer(3);
    ch_wr_en = 1'b1; ch_wr_sel = 2'd1; ch_wr_data = 32'd8; tick;
    ch_wr_en = 1'b0;
    chk("t3_no_commit", compare_value, set1);
    wait_timer(9);
    commit = 1'b1; tick;
    commit = 1'b0;
    chk("t3_staged", compare_value, set2);
    q.push_back(set2);
    wdog_frames = 8'd3;
    q.push_back(set2);
    q.push_back(set2);
    for (int i = 0; i < 3; i++) begin
      wait_timer(9);
      tick;
      if (i < 2) chk("t4_armed", state, 1);
    end
    chk("t4_failsafe", {failsafe, state}, {1'b1, 2'd2});
    chk("t4_idle", compare_value, idle4);
    q.push_back(idle4);
    arm_req = 1'b0; tick;
    chk("t4_disarm", state, 0);
    arm_req = 1'b1;
    q.push_back(idle4);
    wait_timer(9); tick;
    wait_timer(9); tick;
    chk("t4_no_rearm", state, 0);
    wdog_frames = 8'd1;
    wait_timer(2);
    commit = 1'b1; tick;
    commit = 1'b0;
    q.push_back(idle4);
    wait_timer(9); tick;
    chk("t5_armed", state, 1);
    for (int i = 0; i < 4; i++) q.push_back(set2);
    for (int i = 0; i < 4; i++) begin
      wait_timer(9);
      commit = 1'b1; tick;
      commit = 1'b0;
      chk("t5_stay_armed", state, 1);
    end
    q.push_back(set2);
    wait_timer(9); tick;
    chk("t5_expire", state, 2);
    arm_req = 1'b0; tick;
    chk("t5_disarm", state, 0);
    wdog_frames = 8'd0;
    commit = 1'b1; arm_req = 1'b1; tick;
    commit = 1'b0;
    q.push_back(idle4);
    wait_timer(9); tick;
    chk("t6_armed", state, 1);
    wait_timer(5);
    #2 rstn = 1'b0;
    #1;
    chk("t6_timer", timer_value, 0);
    chk("t6_state", {failsafe, state}, 0);
    chk("t6_latch", compare_value_latch, 0);
    chk("t6_cv", compare_value, idle4);
    #1 rstn = 1'b1;
    tick;
    wr3 = 1'b1; sel3 = 2'd0; dat3 = 32'd1; tick;
    sel3 = 2'd1; dat3 = 32'd2; tick;
    sel3 = 2'd2; dat3 = 32'd3; tick;
    sel3 = 2'd3; dat3 = 32'd99; tick;
    wr3 = 1'b0; com3 = 1'b1; arm3 = 1'b1; tick;
    com3 = 1'b0;
    for (int n = 0; n < 12 && st3 != 2'd1; n++) tick;
    chk("oob_state", st3, 1);
    chk("oob_cv", cv3, {32'd3, 32'd2, 32'd1});
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
